// File: rtl/rx_detection_reporter.sv
// rx_detection_reporter: queues peak-detection events in a small FIFO and hands them to the ARM over a 4-phase valid/ack handshake
//   crx_clk, rrx_rst            clock, synchronous active-high reset
//   erx_en                      enable; low flushes everything on the edge
//   ipeak, iseq_id, itime       event payload, sampled on the trigger's rising edge
//   itrigger                    detection trigger (rising edge = event)
//   iarm_ack                    ARM acknowledge (4-phase)
//   iclr_overflow               clears the sticky overflow flag
//   o_valid, o_peak, o_seq, o_time   presented entry
//   o_level                     entries waiting in the FIFO (excluding the presented one)
//   o_overflow                  sticky: an event was dropped on a full FIFO
module rx_detection_reporter #(
    parameter int                 DEPTH    = 4,
    parameter logic signed [15:0] MIN_PEAK = 16'sd0
) (
    input  logic                     crx_clk,
    input  logic                     rrx_rst,
    input  logic                     erx_en,
    input  logic signed [15:0]       ipeak,
    input  logic [3:0]               iseq_id,
    input  logic [15:0]              itime,
    input  logic                     itrigger,
    input  logic                     iarm_ack,
    input  logic                     iclr_overflow,
    output logic                     o_valid,
    output logic signed [15:0]       o_peak,
    output logic [3:0]               o_seq,
    output logic [15:0]              o_time,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, VALID, RELEASE} state_t;
    state_t        state, state_nx;
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          rtrig_d, trig_event, keep, full, push, pop, drop;
    always_comb begin
        trig_event = itrigger & ~rtrig_d & erx_en;
        keep       = trig_event && ipeak >= MIN_PEAK;
        full       = o_level == (AW+1)'(DEPTH);
        // the FSM only pops from a registered non-empty level, so pop never meets an empty FIFO
        pop        = state == IDLE && o_level != '0;
        push       = keep && (!full || pop);
        drop       = keep && full && !pop;
        state_nx   = pop                          ? VALID   :
                     (state == VALID && iarm_ack)   ? RELEASE :
                     (state == RELEASE && !iarm_ack) ? IDLE    : state;
    end
    always_ff @(posedge crx_clk)
        if (push) mem[wr_ptr] <= {ipeak, iseq_id, itime};
    always_ff @(posedge crx_clk) begin
        if (rrx_rst || !erx_en) begin
            state      <= IDLE;
            rtrig_d    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_level    <= '0;
            o_valid    <= 1'b0;
            o_peak     <= '0;
            o_seq      <= '0;
            o_time     <= '0;
            o_overflow <= 1'b0;
        end else begin
            state   <= state_nx;
            rtrig_d <= itrigger;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                {o_peak, o_seq, o_time} <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            o_level    <= (push && !pop) ? o_level + 1'b1 :
                          (pop && !push) ? o_level - 1'b1 : o_level;
            o_valid    <= pop ? 1'b1 : (state == VALID && iarm_ack) ? 1'b0 : o_valid;
            // a drop in the same cycle as a clear keeps the flag set
            o_overflow <= drop | (o_overflow & ~iclr_overflow);
        end
    end
endmodule

// File: tb/tb_rx_detection_reporter.sv
// tb_rx_detection_reporter: directed scenarios plus randomized traffic against a queue-based reference model
module tb_rx_detection_reporter;
    localparam int DEPTH = 4;
    localparam logic signed [15:0] MINP = 16'sd100;
    logic crx_clk = 1'b0;
    always #5 crx_clk = ~crx_clk;
    logic rrx_rst, erx_en, itrigger, iarm_ack, iclr_overflow;
    logic signed [15:0] ipeak;
    logic [3:0] iseq_id;
    logic [15:0] itime;
    logic o_valid, o_overflow;
    logic signed [15:0] o_peak;
    logic [3:0] o_seq;
    logic [15:0] o_time;
    logic [2:0] o_level;
    int tests = 0, fails = 0;
    logic [35:0] q[$];
    bit m_td, m_valid, m_ovf;
    logic [15:0] m_peak, m_time;
    logic [3:0] m_seq;
    int m_phase;

    rx_detection_reporter #(.DEPTH(DEPTH), .MIN_PEAK(MINP)) dut (
        .crx_clk(crx_clk), .rrx_rst(rrx_rst), .erx_en(erx_en), .ipeak(ipeak),
        .iseq_id(iseq_id), .itime(itime), .itrigger(itrigger), .iarm_ack(iarm_ack),
        .iclr_overflow(iclr_overflow), .o_valid(o_valid), .o_peak(o_peak), .o_seq(o_seq),
        .o_time(o_time), .o_level(o_level), .o_overflow(o_overflow));

    // Reference: a queue of waiting events, a presented slot, and the handshake phase
    // (0 = waiting for an entry, 1 = waiting for ack, 2 = waiting for ack release).
    task automatic model_edge();
        bit ev, take;
        if (rrx_rst || !erx_en) begin
            q.delete();
            m_td = 0; m_valid = 0; m_ovf = 0; m_phase = 0;
            m_peak = 0; m_seq = 0; m_time = 0;
        end else begin
            ev = itrigger && !m_td;
            take = m_phase == 0 && q.size() > 0;
            m_td = itrigger;
            if (take) begin
                {m_peak, m_seq, m_time} = q.pop_front();
                m_valid = 1; m_phase = 1;
            end else if (m_phase == 1 && iarm_ack) begin
                m_valid = 0; m_phase = 2;
            end else if (m_phase == 2 && !iarm_ack) m_phase = 0;
            if (ev && ipeak >= MINP && q.size() >= DEPTH) m_ovf = 1;
            else if (iclr_overflow) m_ovf = 0;
            if (ev && ipeak >= MINP && q.size() < DEPTH) q.push_back({ipeak, iseq_id, itime});
        end
    endtask

    task automatic cyc();
        @(posedge crx_clk);
        model_edge();
        @(negedge crx_clk);
    endtask

    task automatic pulse(input logic [15:0] p, input logic [3:0] s, input logic [15:0] t);
        ipeak = p; iseq_id = s; itime = t; itrigger = 1;
        cyc();
        itrigger = 0;
    endtask

    task automatic handshake();
        iarm_ack = 1; cyc();
        iarm_ack = 0; cyc(); cyc();
    endtask

    task automatic test_reset();
        rrx_rst = 1; erx_en = 1; itrigger = 1; iarm_ack = 0; iclr_overflow = 0;
        ipeak = 16'sd500; iseq_id = 3; itime = 16'h55aa;
        cyc(); cyc();
        tests++;
        if ({o_valid, o_overflow, o_level, o_peak, o_seq, o_time} !== 39'd0) begin
            fails++;
            $display("FAIL reset: got v=%0b ovf=%0b lvl=%0d peak=%0d seq=%0d time=%h want all 0",
                     o_valid, o_overflow, o_level, o_peak, o_seq, o_time);
        end
        rrx_rst = 0; itrigger = 0; cyc();
    endtask

    task automatic test_single();
        pulse(16'sd300, 4'd5, 16'h1234);
        tests++;
        if (o_valid !== 1'b0) begin fails++; $display("FAIL single_early: o_valid=%0b want 0 at T+1", o_valid); end
        cyc();
        tests++;
        if ({o_valid, o_peak, o_seq, o_time} !== {1'b1, 16'sd300, 4'd5, 16'h1234}) begin
            fails++;
            $display("FAIL single_present: got v=%0b %0d/%0d/%h want 1 300/5/1234", o_valid, o_peak, o_seq, o_time);
        end
        iarm_ack = 1; cyc();
        tests++;
        if (o_valid !== 1'b0) begin fails++; $display("FAIL single_ack: o_valid=%0b want 0", o_valid); end
        iarm_ack = 0; cyc(); cyc(); cyc();
        tests++;
        if ({o_valid, o_level, o_peak} !== {1'b0, 3'd0, 16'sd300}) begin
            fails++;
            $display("FAIL single_done: got v=%0b lvl=%0d peak=%0d want 0 0 300", o_valid, o_level, o_peak);
        end
    endtask

    task automatic test_held();
        ipeak = 16'sd150; iseq_id = 2; itime = 16'h0042; itrigger = 1;
        for (int i = 0; i < 20; i++) cyc();
        tests++;
        if ({o_valid, o_level, o_peak} !== {1'b1, 3'd0, 16'sd150}) begin
            fails++;
            $display("FAIL held_one: got v=%0b lvl=%0d peak=%0d want 1 0 150", o_valid, o_level, o_peak);
        end
        itrigger = 0;
        handshake();
        cyc(); cyc();
        tests++;
        if ({o_valid, o_level} !== {1'b0, 3'd0}) begin
            fails++;
            $display("FAIL held_extra: got v=%0b lvl=%0d want 0 0", o_valid, o_level);
        end
    endtask

    task automatic test_threshold();
        pulse(-16'sd50, 4'd1, 16'd10); cyc();
        pulse(16'sd99, 4'd2, 16'd11); cyc(); cyc();
        tests++;
        if ({o_valid, o_level, o_overflow} !== 5'd0) begin
            fails++;
            $display("FAIL thresh_drop: got v=%0b lvl=%0d ovf=%0b want 0 0 0", o_valid, o_level, o_overflow);
        end
        pulse(16'sd100, 4'd3, 16'd12); cyc();
        tests++;
        if ({o_valid, o_peak, o_seq} !== {1'b1, 16'sd100, 4'd3}) begin
            fails++;
            $display("FAIL thresh_pass: got v=%0b peak=%0d seq=%0d want 1 100 3", o_valid, o_peak, o_seq);
        end
        handshake();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 6; i++) begin
            pulse(16'(100 + i), 4'(i), 16'(16'h0100 + i));
            cyc();
        end
        tests++;
        if ({o_valid, o_peak, o_level, o_overflow} !== {1'b1, 16'sd101, 3'd4, 1'b1}) begin
            fails++;
            $display("FAIL ovf_state: got v=%0b peak=%0d lvl=%0d ovf=%0b want 1 101 4 1", o_valid, o_peak, o_level, o_overflow);
        end
        iclr_overflow = 1; cyc(); iclr_overflow = 0;
        tests++;
        if (o_overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: ovf=%0b want 0", o_overflow); end
        iarm_ack = 1; cyc();
        iarm_ack = 0; cyc();
        pulse(16'sd107, 4'd7, 16'h0107);
        tests++;
        if ({o_valid, o_peak, o_level, o_overflow} !== {1'b1, 16'sd102, 3'd4, 1'b0}) begin
            fails++;
            $display("FAIL full_pushpop: got v=%0b peak=%0d lvl=%0d ovf=%0b want 1 102 4 0", o_valid, o_peak, o_level, o_overflow);
        end
        for (int k = 0; k < 4; k++) begin
            handshake();
            tests++;
            if ({o_valid, o_peak} !== {1'b1, 16'(k == 3 ? 107 : 103 + k)}) begin
                fails++;
                $display("FAIL drain_%0d: got v=%0b peak=%0d want 1 %0d", k, o_valid, o_peak, k == 3 ? 107 : 103 + k);
            end
        end
        handshake();
        tests++;
        if ({o_valid, o_level} !== {1'b0, 3'd0}) begin
            fails++;
            $display("FAIL drain_empty: got v=%0b lvl=%0d want 0 0", o_valid, o_level);
        end
    endtask

    task automatic test_disable();
        pulse(16'sd400, 4'd9, 16'h0a0a); cyc();
        pulse(16'sd401, 4'd10, 16'h0b0b); cyc();
        erx_en = 0; cyc(); erx_en = 1;
        tests++;
        if ({o_valid, o_level, o_overflow, o_peak, o_seq, o_time} !== 39'd0) begin
            fails++;
            $display("FAIL disable_flush: got v=%0b lvl=%0d ovf=%0b peak=%0d seq=%0d time=%h want all 0",
                     o_valid, o_level, o_overflow, o_peak, o_seq, o_time);
        end
        pulse(16'sd200, 4'd4, 16'hbeef); cyc();
        tests++;
        if ({o_valid, o_peak, o_seq, o_time} !== {1'b1, 16'sd200, 4'd4, 16'hbeef}) begin
            fails++;
            $display("FAIL disable_after: got v=%0b %0d/%0d/%h want 1 200/4/beef", o_valid, o_peak, o_seq, o_time);
        end
        handshake();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rrx_rst = $urandom_range(0, 199) == 0;
            erx_en = $urandom_range(0, 39) != 0;
            itrigger = $urandom_range(0, 2) == 0;
            iarm_ack = $urandom_range(0, 1) == 1;
            iclr_overflow = $urandom_range(0, 9) == 0;
            ipeak = $urandom_range(0, 4) == 0 ? 16'($urandom) : 16'($urandom_range(0, 300)) - 16'sd100;
            iseq_id = 4'($urandom);
            itime = 16'($urandom);
            cyc();
            tests++;
            if ({o_valid, o_peak, o_seq, o_time, o_level, o_overflow} !==
                {m_valid, m_peak, m_seq, m_time, 3'(q.size()), m_ovf}) begin
                fails++;
                $display("FAIL random_%0d: got v=%0b %0d/%0d/%h lvl=%0d ovf=%0b want v=%0b %0d/%0d/%h lvl=%0d ovf=%0b",
                         i, o_valid, o_peak, o_seq, o_time, o_level, o_overflow,
                         m_valid, $signed(m_peak), m_seq, m_time, q.size(), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held();
        test_threshold();
        test_overflow();
        test_disable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
